// File: rtl/pesagem_pkg.sv
// Shared types, widths and helpers for the scale weighing controller.
package pesagem_pkg;

   localparam int W_G     = 12;
   localparam int W_RESTO = 10;
   localparam int W_SOMA  = 14;
   localparam int W_DIF   = 13;
   localparam int MIL     = 1000;

   typedef enum logic [1:0] {
      ACUM,
      SUB,
      DIV,
      OUT
   } estado_t;

   // Absolute difference of two unsigned gram values, one bit wider so it never wraps.
   function automatic logic [W_DIF-1:0] difAbs(input logic [W_G-1:0] a, input logic [W_G-1:0] b);
      if (a >= b)
         difAbs = {1'b0, a} - {1'b0, b};
      else
         difAbs = {1'b0, b} - {1'b0, a};
   endfunction

endpackage

// File: rtl/divisor_seq.sv
// Sequential restoring divider of a 12-bit dividend by the constant 1000.
// The start cycle already performs the first quotient bit, so the result is
// ready (done pulses) eleven cycles after start and is held until the next start.
module divisor_seq
   import pesagem_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start_i,
   input  logic [W_G-1:0]     dividendo_i,
   output logic               busy_o,
   output logic               done_o,
   output logic [W_G-1:0]     quociente_o,
   output logic [W_RESTO-1:0] resto_o
);

   logic [W_RESTO-1:0] resto_q, resto_d;
   logic [W_G-1:0]     quoc_q, quoc_d;
   logic [3:0]         cont_q, cont_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   // One restoring step: shift the next dividend bit into the partial remainder,
   // subtract 1000 when it fits, and shift the resulting quotient bit in at the bottom.
   function automatic logic [W_RESTO+W_G-1:0] passo(input logic [W_RESTO-1:0] r,
                                                    input logic [W_G-1:0]     q);
      logic [W_RESTO:0] tentativa;
      logic             cabe;
      tentativa = {r, q[W_G-1]};
      cabe      = (tentativa >= (W_RESTO+1)'(MIL));
      if (cabe)
         tentativa = tentativa - (W_RESTO+1)'(MIL);
      return {tentativa[W_RESTO-1:0], q[W_G-2:0], cabe};
   endfunction

   // Next-state logic: load and do the first step on start, then one step per cycle.
   always_comb begin
      resto_d = resto_q;
      quoc_d  = quoc_q;
      cont_d  = cont_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      if (start_i) begin
         {resto_d, quoc_d} = passo('0, dividendo_i);
         cont_d            = 4'(W_G - 1);
         busy_d            = 1'b1;
      end else if (busy_q) begin
         {resto_d, quoc_d} = passo(resto_q, quoc_q);
         cont_d            = cont_q - 4'd1;
         if (cont_q == 4'd1) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   // Divider registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         resto_q <= '0;
         quoc_q  <= '0;
         cont_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         resto_q <= resto_d;
         quoc_q  <= quoc_d;
         cont_q  <= cont_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign quociente_o = quoc_q;
   assign resto_o     = resto_q;

endmodule

// File: rtl/pesagem_ctrl.sv
// Weighing controller: averages a window of gram samples, applies the tare with
// a clamp at zero, splits the net weight into kg and grams and flags stability.
module pesagem_ctrl
   import pesagem_pkg::*;
#(
   parameter int N_LOG2         = 2,
   parameter int TARA_INICIAL   = 40,
   parameter int LIMIAR_ESTAVEL = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [W_G-1:0]     gramas,
   input  logic               gramas_valid,
   output logic               sample_ready,
   input  logic               tara_cmd,
   output logic [W_G-1:0]     pesokg,
   output logic [W_RESTO-1:0] resto_g,
   output logic               estavel,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [W_G-1:0]     tara_atual,
   output logic               tara_pendente
);

   localparam int               W_CNT  = N_LOG2 + 1;
   localparam logic [W_CNT-1:0] JANELA = W_CNT'(1 << N_LOG2);

   estado_t            estado_q, estado_d;
   logic [W_SOMA-1:0]  soma_q, soma_d;
   logic [W_CNT-1:0]   cnt_q, cnt_d;
   logic [W_G-1:0]     tara_q, tara_d;
   logic               pend_q, pend_d;
   logic [W_G-1:0]     mediaAnt_q, mediaAnt_d;
   logic               antValido_q, antValido_d;
   logic               estavelN_q, estavelN_d;
   logic [W_G-1:0]     pesokg_q, pesokg_d;
   logic [W_RESTO-1:0] resto_q, resto_d;
   logic               estavel_q, estavel_d;

   logic               janelaCheia;
   logic               aceita;
   logic [W_G-1:0]     media;
   logic [W_G-1:0]     liquido;
   logic [W_DIF-1:0]   dif;
   logic               divStart;
   logic               divBusy;
   logic               divDone;
   logic [W_G-1:0]     divQuoc;
   logic [W_RESTO-1:0] divResto;

   assign janelaCheia = (cnt_q == JANELA);
   assign sample_ready = (estado_q == ACUM) && !janelaCheia;
   assign aceita       = gramas_valid && sample_ready;
   assign media        = W_G'(soma_q >> N_LOG2);
   assign liquido      = (media > tara_q) ? (media - tara_q) : '0;
   assign dif          = difAbs(media, mediaAnt_q);

   divisor_seq u_div (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (divStart),
      .dividendo_i (liquido),
      .busy_o      (divBusy),
      .done_o      (divDone),
      .quociente_o (divQuoc),
      .resto_o     (divResto)
   );

   // FSM next state plus every datapath register update; everything holds by default.
   always_comb begin
      estado_d    = estado_q;
      soma_d      = soma_q;
      cnt_d       = cnt_q;
      tara_d      = tara_q;
      pend_d      = pend_q | tara_cmd;
      mediaAnt_d  = mediaAnt_q;
      antValido_d = antValido_q;
      estavelN_d  = estavelN_q;
      pesokg_d    = pesokg_q;
      resto_d     = resto_q;
      estavel_d   = estavel_q;
      divStart    = 1'b0;
      unique case (estado_q)
         ACUM: begin
            if (aceita) begin
               soma_d = soma_q + W_SOMA'(gramas);
               cnt_d  = cnt_q + W_CNT'(1);
            end
            if (janelaCheia)
               estado_d = SUB;
         end
         SUB: begin
            if (pend_q) begin
               tara_d   = media;
               pend_d   = tara_cmd;
               soma_d   = '0;
               cnt_d    = '0;
               estado_d = ACUM;
            end else begin
               estavelN_d  = antValido_q && (dif <= W_DIF'(LIMIAR_ESTAVEL));
               mediaAnt_d  = media;
               antValido_d = 1'b1;
               divStart    = !divBusy;
               estado_d    = DIV;
            end
         end
         DIV: begin
            if (divDone) begin
               pesokg_d  = divQuoc;
               resto_d   = divResto;
               estavel_d = estavelN_q;
               estado_d  = OUT;
            end
         end
         OUT: begin
            if (out_ready) begin
               soma_d   = '0;
               cnt_d    = '0;
               estado_d = ACUM;
            end
         end
         default: estado_d = ACUM;
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         estado_q    <= ACUM;
         soma_q      <= '0;
         cnt_q       <= '0;
         tara_q      <= W_G'(TARA_INICIAL);
         pend_q      <= 1'b0;
         mediaAnt_q  <= '0;
         antValido_q <= 1'b0;
         estavelN_q  <= 1'b0;
         pesokg_q    <= '0;
         resto_q     <= '0;
         estavel_q   <= 1'b0;
      end else begin
         estado_q    <= estado_d;
         soma_q      <= soma_d;
         cnt_q       <= cnt_d;
         tara_q      <= tara_d;
         pend_q      <= pend_d;
         mediaAnt_q  <= mediaAnt_d;
         antValido_q <= antValido_d;
         estavelN_q  <= estavelN_d;
         pesokg_q    <= pesokg_d;
         resto_q     <= resto_d;
         estavel_q   <= estavel_d;
      end
   end

   assign out_valid     = (estado_q == OUT);
   assign pesokg        = pesokg_q;
   assign resto_g       = resto_q;
   assign estavel       = estavel_q;
   assign tara_atual    = tara_q;
   assign tara_pendente = pend_q;

endmodule

// File: tb/tb_pesagem_ctrl.sv
// Self-checking bench for pesagem_ctrl: a table of directed windows, hand-written
// corner sequences, and random windows checked against an arithmetic reference model.
module tb_pesagem_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [11:0] gramas;
   logic        gramas_valid;
   logic        sample_ready;
   logic        tara_cmd;
   logic [11:0] pesokg;
   logic [9:0]  resto_g;
   logic        estavel;
   logic        out_valid;
   logic        out_ready;
   logic [11:0] tara_atual;
   logic        tara_pendente;

   pesagem_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .gramas        (gramas),
      .gramas_valid  (gramas_valid),
      .sample_ready  (sample_ready),
      .tara_cmd      (tara_cmd),
      .pesokg        (pesokg),
      .resto_g       (resto_g),
      .estavel       (estavel),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .tara_atual    (tara_atual),
      .tara_pendente (tara_pendente)
   );

   // Free-running clock and an edge counter used to measure latency.
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [3:0][11:0] s;
      logic             tc;
      logic             res;
      logic [11:0]      kg;
      logic [9:0]       g;
      logic             est;
      logic [11:0]      tara;
   } vec_t;

   vec_t tbl[13];
   int   nAssert = 0;
   int   nFail   = 0;
   int   eCyc    = 0;
   bit   readyHeld = 1'b0;

   // Reference model state: the behaviour expressed as plain arithmetic on windows.
   int taraM = 40;
   int mediaAntM = 0;
   bit antM = 1'b0;
   bit pendM = 1'b0;

   function automatic vec_t mk(input int a, input int b, input int c, input int d, input bit tc,
                               input bit res, input int kg, input int g, input bit est, input int tara);
      vec_t v;
      v.s    = {12'(d), 12'(c), 12'(b), 12'(a)};
      v.tc   = tc;
      v.res  = res;
      v.kg   = 12'(kg);
      v.g    = 10'(g);
      v.est  = est;
      v.tara = 12'(tara);
      return v;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      nAssert++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: actual %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic modelReset();
      taraM = 40;
      mediaAntM = 0;
      antM = 1'b0;
      pendM = 1'b0;
   endtask

   task automatic modelWindow(input logic [3:0][11:0] s, input bit tc, output bit res,
                              output int kg, output int g, output bit est, output int tara);
      int soma, media, liq, d;
      if (tc) pendM = 1'b1;
      soma  = int'(s[0]) + int'(s[1]) + int'(s[2]) + int'(s[3]);
      media = soma / 4;
      if (pendM) begin
         taraM = media;
         pendM = 1'b0;
         res = 1'b0; kg = 0; g = 0; est = 1'b0;
      end else begin
         liq = (media > taraM) ? media - taraM : 0;
         kg  = liq / 1000;
         g   = liq % 1000;
         d   = (media > mediaAntM) ? media - mediaAntM : mediaAntM - media;
         est = antM && (d <= 5);
         mediaAntM = media;
         antM = 1'b1;
         res = 1'b1;
      end
      tara = taraM;
   endtask

   task automatic pushSample(input logic [11:0] v, input bit tc);
      int t = 0;
      gramas = v;
      gramas_valid = 1'b1;
      tara_cmd = tc;
      while (!sample_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!sample_ready) chk("pushTimeout", 0, 1);
      @(posedge clk);
      @(negedge clk);
      gramas_valid = 1'b0;
      tara_cmd = 1'b0;
   endtask

   task automatic applyStimulus(input logic [3:0][11:0] s, input bit tc);
      for (int i = 0; i < 4; i++) pushSample(s[i], tc && (i == 3));
      eCyc = cyc;
      if (tc) chk("pendSet", tara_pendente, 1);
   endtask

   task automatic checkOutput(input string nm, input bit res, input int kg, input int g,
                              input bit est, input int tara);
      int t = 0;
      bit seen = 1'b0;
      if (!res) begin
         while (cyc < eCyc + 2) @(negedge clk);
         chk({nm, "_tara"}, tara_atual, tara);
         chk({nm, "_pendClr"}, tara_pendente, 0);
         chk({nm, "_readyBack"}, sample_ready, 1);
         repeat (16) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
         end
         chk({nm, "_noOut"}, seen, 0);
      end else begin
         while (!out_valid && t < 40) begin
            @(negedge clk);
            t++;
         end
         chk({nm, "_valid"}, out_valid, 1);
         chk({nm, "_lat"}, cyc - eCyc, 14);
         chk({nm, "_kg"}, pesokg, kg);
         chk({nm, "_g"}, resto_g, g);
         chk({nm, "_est"}, estavel, est);
         chk({nm, "_tara"}, tara_atual, tara);
         out_ready = 1'b1;
         @(negedge clk);
         chk({nm, "_pulse"}, out_valid, 0);
         chk({nm, "_readyBack"}, sample_ready, 1);
         out_ready = readyHeld;
      end
   endtask

   // Global watchdog so the run always ends.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: actual timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main test sequence.
   initial begin
      bit  mRes, mEst;
      int  mKg, mG, mTara, base, prevBase;
      logic [3:0][11:0] s;
      bit  tc, seen;

      tbl[0]  = mk(1040, 1040, 1040, 1040, 0, 1, 1, 0,   0, 40);
      tbl[1]  = mk(2500, 2500, 2502, 2502, 0, 1, 2, 461, 0, 40);
      tbl[2]  = mk(2500, 2500, 2502, 2502, 0, 1, 2, 461, 1, 40);
      tbl[3]  = mk(2600, 2600, 2600, 2600, 0, 1, 2, 560, 0, 40);
      tbl[4]  = mk(300,  300,  300,  300,  1, 0, 0, 0,   0, 300);
      tbl[5]  = mk(1300, 1300, 1300, 1300, 0, 1, 1, 0,   0, 300);
      tbl[6]  = mk(40,   40,   40,   40,   1, 0, 0, 0,   0, 40);
      tbl[7]  = mk(20,   20,   20,   20,   0, 1, 0, 0,   0, 40);
      tbl[8]  = mk(25,   25,   25,   25,   0, 1, 0, 0,   1, 40);
      tbl[9]  = mk(31,   31,   31,   31,   0, 1, 0, 0,   0, 40);
      tbl[10] = mk(4095, 4095, 4095, 4095, 0, 1, 4, 55,  0, 40);
      tbl[11] = mk(1045, 1043, 1041, 1039, 0, 1, 1, 2,   0, 40);
      tbl[12] = mk(4,    5,    6,    7,    0, 1, 0, 0,   0, 40);

      rst_n = 1'b0;
      gramas = '0;
      gramas_valid = 1'b0;
      tara_cmd = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      chk("rst_sampleReady", sample_ready, 1);
      chk("rst_outValid", out_valid, 0);
      chk("rst_kg", pesokg, 0);
      chk("rst_g", resto_g, 0);
      chk("rst_est", estavel, 0);
      chk("rst_tara", tara_atual, 40);
      chk("rst_pend", tara_pendente, 0);

      for (int i = 0; i < 13; i++) begin
         applyStimulus(tbl[i].s, tbl[i].tc);
         modelWindow(tbl[i].s, tbl[i].tc, mRes, mKg, mG, mEst, mTara);
         checkOutput($sformatf("vec%0d", i), tbl[i].res, int'(tbl[i].kg), int'(tbl[i].g),
                     tbl[i].est, int'(tbl[i].tara));
      end

      $display("[TB] backpressure hold in OUT");
      s = {12'd1040, 12'd1040, 12'd1040, 12'd1040};
      applyStimulus(s, 1'b0);
      modelWindow(s, 1'b0, mRes, mKg, mG, mEst, mTara);
      for (int t = 0; t < 40 && !out_valid; t++) @(negedge clk);
      gramas = 12'd999;
      gramas_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk($sformatf("hold%0d", k), {out_valid, sample_ready, pesokg, resto_g, estavel},
             {1'b1, 1'b0, 12'(mKg), 10'(mG), mEst});
      end
      gramas_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("holdRelease_valid", out_valid, 0);
      chk("holdRelease_ready", sample_ready, 1);
      s = {12'd1040, 12'd1040, 12'd1040, 12'd1040};
      applyStimulus(s, 1'b0);
      modelWindow(s, 1'b0, mRes, mKg, mG, mEst, mTara);
      checkOutput("afterHold", mRes, mKg, mG, mEst, mTara);

      $display("[TB] reset during division");
      s = {12'd300, 12'd300, 12'd300, 12'd300};
      applyStimulus(s, 1'b1);
      modelWindow(s, 1'b1, mRes, mKg, mG, mEst, mTara);
      checkOutput("tare300", mRes, mKg, mG, mEst, mTara);
      s = {12'd1300, 12'd1300, 12'd1300, 12'd1300};
      applyStimulus(s, 1'b0);
      while (cyc < eCyc + 5) @(negedge clk);
      tara_cmd = 1'b1;
      @(negedge clk);
      tara_cmd = 1'b0;
      chk("divPend", tara_pendente, 1);
      chk("divTara", tara_atual, 300);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      modelReset();
      chk("midRst_outValid", out_valid, 0);
      chk("midRst_sampleReady", sample_ready, 1);
      chk("midRst_kg", pesokg, 0);
      chk("midRst_g", resto_g, 0);
      chk("midRst_est", estavel, 0);
      chk("midRst_tara", tara_atual, 40);
      chk("midRst_pend", tara_pendente, 0);
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      chk("midRst_noOut", seen, 0);
      s = {12'd1040, 12'd1040, 12'd1040, 12'd1040};
      applyStimulus(s, 1'b0);
      modelWindow(s, 1'b0, mRes, mKg, mG, mEst, mTara);
      checkOutput("afterRst", mRes, mKg, mG, mEst, mTara);

      $display("[TB] random windows with out_ready held high");
      readyHeld = 1'b1;
      out_ready = 1'b1;
      prevBase = 1000;
      for (int w = 0; w < 24; w++) begin
         if ($urandom_range(0, 2) == 0)
            base = prevBase + int'($urandom_range(0, 8)) - 4;
         else
            base = int'($urandom_range(0, 4090));
         if (base < 0) base = 0;
         if (base > 4090) base = 4090;
         for (int i = 0; i < 4; i++) s[i] = 12'(base + int'($urandom_range(0, 4)));
         tc = ($urandom_range(0, 5) == 0);
         prevBase = base;
         applyStimulus(s, tc);
         modelWindow(s, tc, mRes, mKg, mG, mEst, mTara);
         checkOutput($sformatf("rnd%0d", w), mRes, mKg, mG, mEst, mTara);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

endmodule
